// File: rtl/mem_readback_scanner.sv
// Readback engine for a block RAM with one-cycle registered read latency: sweeps every
// address, streams the words over valid/ready and accumulates a rotate-XOR signature.
module mem_readback_scanner #(
    parameter int WID_MEM   = 16,
    parameter int DEPTH_MEM = 2048
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [31:0]        o_raddr,
    input  logic [WID_MEM-1:0] i_mem_dout,
    output logic [WID_MEM-1:0] o_out_data,
    output logic [31:0]        o_out_index,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [31:0]        o_checksum
);
    localparam int            AW        = $clog2(DEPTH_MEM);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_issue_cnt;
    logic [AW-1:0]      r_beat_cnt;
    logic [AW-1:0]      r_raddr;
    logic               r_inflight;
    logic [1:0]         r_occ;
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [31:0]        r_checksum;
    logic [WID_MEM-1:0] r_fifo_data [2];
    logic [AW-1:0]      r_fifo_idx  [2];

    logic               w_start_acc;
    logic               w_valid;
    logic               w_pop;
    logic               w_issue;
    logic [WID_MEM-1:0] w_head_data;
    logic [AW-1:0]      w_head_idx;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_head_data = '0;
        w_head_idx  = '0;

        // The word landing from the RAM this cycle falls straight through to the head.
        if (r_occ != 2'd0) begin
            w_head_data = r_fifo_data[r_rd_ptr];
            w_head_idx  = r_fifo_idx[r_rd_ptr];
        end else if (r_inflight) begin
            w_head_data = i_mem_dout;
            w_head_idx  = r_raddr;
        end

        w_valid = (r_occ != 2'd0) || r_inflight;
        w_pop   = w_valid && i_out_ready;
        w_issue = (r_state == S_SWEEP) &&
                  ((3'(r_occ) + 3'(r_inflight) - 3'(w_pop)) < 3'd2);

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (w_issue && (r_issue_cnt == LAST_ADDR)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_beat_cnt == LAST_ADDR)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_FINISH);
    assign o_raddr     = 32'(w_issue ? r_issue_cnt : r_raddr);
    assign o_out_data  = w_head_data;
    assign o_out_index = 32'(w_head_idx);
    assign o_out_valid = w_valid;
    assign o_checksum  = r_checksum;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_raddr     <= '0;
            r_inflight  <= 1'b0;
            r_occ       <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_issue_cnt <= '0;
                r_beat_cnt  <= '0;
                r_checksum  <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + AW'(1);
                    r_raddr     <= r_issue_cnt;
                end
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + AW'(1);
                    r_checksum <= {r_checksum[30:0], r_checksum[31]} ^ 32'(w_head_data);
                end
            end
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
        end
    end

    // NOTE: FIFO storage has no reset; the occupancy count alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (r_inflight) begin
            r_fifo_data[r_wr_ptr] <= i_mem_dout;
            r_fifo_idx[r_wr_ptr]  <= r_raddr;
        end
    end

endmodule

// File: tb/tb_mem_readback_scanner.sv
// Self-checking bench: a 4-word instance for exact timing/corner cases and a default-size
// instance for full-rate and randomized-backpressure sweeps against a behavioural model.
module tb_mem_readback_scanner;
    localparam int S_DEPTH = 4;
    localparam int B_DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset, s_start, s_ready, s_busy, s_done, s_valid;
    logic [31:0] s_raddr, s_index, s_cks;
    logic [15:0] s_dout, s_data;
    logic [15:0] s_mem [S_DEPTH];

    logic        b_reset, b_start, b_ready, b_busy, b_done, b_valid;
    logic [31:0] b_raddr, b_index, b_cks;
    logic [15:0] b_dout, b_data;
    logic [15:0] b_mem [B_DEPTH];

    mem_readback_scanner #(.WID_MEM(16), .DEPTH_MEM(S_DEPTH)) u_small (
        .i_clk(clk), .i_reset(s_reset), .i_start(s_start), .o_busy(s_busy), .o_done(s_done),
        .o_raddr(s_raddr), .i_mem_dout(s_dout), .o_out_data(s_data), .o_out_index(s_index),
        .o_out_valid(s_valid), .i_out_ready(s_ready), .o_checksum(s_cks)
    );

    mem_readback_scanner u_big (
        .i_clk(clk), .i_reset(b_reset), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .o_raddr(b_raddr), .i_mem_dout(b_dout), .o_out_data(b_data), .o_out_index(b_index),
        .o_out_valid(b_valid), .i_out_ready(b_ready), .o_checksum(b_cks)
    );

    // RAM models: registered read, data valid the cycle after the address.
    always @(posedge clk) s_dout <= s_mem[s_raddr[1:0]];
    always @(posedge clk) b_dout <= b_mem[b_raddr[10:0]];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [63:0] init;
        logic [7:0]  ready_pat;
        logic [31:0] exp_cks;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] golden_big();
        logic [31:0] c;
        c = 32'h0;
        for (int i = 0; i < B_DEPTH; i++) begin
            c = (c << 1) | (c >> 31);
            c = c ^ {16'h0, b_mem[i]};
        end
        return c;
    endfunction

    task automatic sweep_small(input logic [63:0] init, input logic [7:0] pat, input bit restart,
                               input logic [31:0] exp_cks, input string tag);
        int          beats;
        int          c;
        int          issued;
        bit          done_seen;
        bit          held;
        bit          restarted;
        logic [15:0] hd;
        logic [31:0] hi;
        beats = 0; c = 0; done_seen = 0; held = 0; restarted = 0; hd = '0; hi = '0;
        for (int i = 0; i < S_DEPTH; i++) s_mem[i] = init[16*i +: 16];
        step();
        s_start = 1'b1;
        s_ready = 1'b0;
        while (!done_seen && c < 200) begin
            c++;
            step();
            s_start = 1'b0;
            if (restart && !restarted && beats == 1) begin
                s_start   = 1'b1;
                restarted = 1'b1;
            end
            s_ready = pat[3'(c % 8)];
            @(negedge clk);
            if (s_busy) begin
                issued = int'(s_raddr) + 1;
                check({tag, " occ<=2"}, 64'((issued - beats - int'(s_valid && s_ready)) <= 2), 64'(1));
            end
            if (s_valid) begin
                if (held) begin
                    check({tag, " stall data"}, 64'(s_data), 64'(hd));
                    check({tag, " stall index"}, 64'(s_index), 64'(hi));
                end
                if (s_ready) begin
                    check({tag, " beat index"}, 64'(s_index), 64'(beats));
                    check({tag, " beat data"}, 64'(s_data), init[16*(beats % S_DEPTH) +: 16]);
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = s_data;
                    hi   = s_index;
                end
            end
            if (s_done) begin
                done_seen = 1'b1;
                check({tag, " busy at done"}, 64'(s_busy), 64'(1));
                check({tag, " checksum"}, 64'(s_cks), 64'(exp_cks));
            end
        end
        check({tag, " done seen"}, 64'(done_seen), 64'(1));
        check({tag, " beat count"}, 64'(beats), 64'(S_DEPTH));
        s_ready = 1'b0;
        step();
        @(negedge clk);
        check({tag, " busy after"}, 64'(s_busy), 64'(0));
        check({tag, " checksum held"}, 64'(s_cks), 64'(exp_cks));
    endtask

    task automatic sweep_big(input bit rnd, input string tag);
        int          beats;
        int          c;
        int          gaps;
        int          issued;
        bit          done_seen;
        bit          held;
        logic [15:0] hd;
        logic [31:0] hi;
        logic [31:0] exp_cks;
        beats = 0; c = 0; gaps = 0; done_seen = 0; held = 0; hd = '0; hi = '0;
        exp_cks = golden_big();
        step();
        b_start = 1'b1;
        b_ready = 1'b0;
        while (!done_seen && c < 20000) begin
            c++;
            step();
            b_start = 1'b0;
            b_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (b_busy) begin
                issued = int'(b_raddr) + 1;
                check({tag, " occ<=2"}, 64'((issued - beats - int'(b_valid && b_ready)) <= 2), 64'(1));
            end
            if (b_valid) begin
                if (held) begin
                    check({tag, " stall data"}, 64'(b_data), 64'(hd));
                    check({tag, " stall index"}, 64'(b_index), 64'(hi));
                end
                if (b_ready) begin
                    check({tag, " beat index"}, 64'(b_index), 64'(beats));
                    check({tag, " beat data"}, 64'(b_data), 64'(b_mem[beats % B_DEPTH]));
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = b_data;
                    hi   = b_index;
                end
            end else if (c >= 2 && beats < B_DEPTH) begin
                gaps++;
            end
            if (b_done) begin
                done_seen = 1'b1;
                check({tag, " busy at done"}, 64'(b_busy), 64'(1));
                check({tag, " checksum"}, 64'(b_cks), 64'(exp_cks));
                if (!rnd) check({tag, " done cycle"}, 64'(c), 64'(B_DEPTH + 2));
            end
        end
        check({tag, " done seen"}, 64'(done_seen), 64'(1));
        check({tag, " beat count"}, 64'(beats), 64'(B_DEPTH));
        if (!rnd) check({tag, " gaps"}, 64'(gaps), 64'(0));
        b_ready = 1'b0;
        step();
        @(negedge clk);
        check({tag, " busy after"}, 64'(b_busy), 64'(0));
    endtask

    initial begin
        int  err_done;
        vecs[0] = '{init: 64'h0003_0002_0001_0000, ready_pat: 8'hFF, exp_cks: 32'h0000_0003};
        vecs[1] = '{init: 64'h000D_000C_000B_000A, ready_pat: 8'hFF, exp_cks: 32'h0000_0069};
        vecs[2] = '{init: 64'h000D_000C_000B_000A, ready_pat: 8'hA9, exp_cks: 32'h0000_0069};
        vecs[3] = '{init: 64'hFFFF_FFFF_FFFF_FFFF, ready_pat: 8'h55, exp_cks: 32'h0005_0005};
        vecs[4] = '{init: 64'h0000_0000_0000_1234, ready_pat: 8'h33, exp_cks: 32'h0000_91A0};
        vecs[5] = '{init: 64'h0003_0002_0001_0000, ready_pat: 8'h0E, exp_cks: 32'h0000_0003};

        s_reset = 1'b1; s_start = 1'b0; s_ready = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_ready = 1'b0;
        for (int i = 0; i < S_DEPTH; i++) s_mem[i] = 16'h0;
        for (int i = 0; i < B_DEPTH; i++) b_mem[i] = 16'h0;
        step();
        step();
        s_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(s_busy), 64'(0));
        check("reset done", 64'(s_done), 64'(0));
        check("reset valid", 64'(s_valid), 64'(0));
        check("reset raddr", 64'(s_raddr), 64'(0));
        check("reset index", 64'(s_index), 64'(0));
        check("reset data", 64'(s_data), 64'(0));
        check("reset checksum", 64'(s_cks), 64'(0));
        check("big reset busy", 64'(b_busy), 64'(0));
        check("big reset valid", 64'(b_valid), 64'(0));
        check("big reset checksum", 64'(b_cks), 64'(0));

        for (int i = 0; i < 6; i++) begin
            sweep_small(vecs[i].init, vecs[i].ready_pat, 1'b0, vecs[i].exp_cks, $sformatf("vec%0d", i));
        end

        // Exact cycle timing of an unstalled 4-word sweep, start at cycle T.
        for (int i = 0; i < S_DEPTH; i++) s_mem[i] = 16'(i);
        step();
        s_start = 1'b1;
        s_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            s_start = 1'b0;
            @(negedge clk);
            check($sformatf("timing busy T+%0d", k), 64'(s_busy), 64'(k <= 6));
            check($sformatf("timing done T+%0d", k), 64'(s_done), 64'(k == 6));
            check($sformatf("timing valid T+%0d", k), 64'(s_valid), 64'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                check($sformatf("timing index T+%0d", k), 64'(s_index), 64'(k - 2));
                check($sformatf("timing data T+%0d", k), 64'(s_data), 64'(k - 2));
            end
            if (k == 1) check("timing raddr T+1", 64'(s_raddr), 64'(0));
            if (k == 6) check("timing checksum", 64'(s_cks), 64'(3));
        end

        sweep_small(64'h0003_0002_0001_0000, 8'hFF, 1'b1, 32'h0000_0003, "restart");
        sweep_small(64'h000D_000C_000B_000A, 8'hA9, 1'b1, 32'h0000_0069, "restart stall");

        // Reset while beat 2 is on the bus.
        step();
        s_start = 1'b1;
        s_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            s_start = 1'b0;
        end
        step();
        s_reset = 1'b1;
        @(negedge clk);
        check("midreset beat2 valid", 64'(s_valid), 64'(1));
        check("midreset beat2 index", 64'(s_index), 64'(2));
        step();
        s_reset = 1'b0;
        @(negedge clk);
        check("midreset valid", 64'(s_valid), 64'(0));
        check("midreset busy", 64'(s_busy), 64'(0));
        check("midreset checksum", 64'(s_cks), 64'(0));
        check("midreset done", 64'(s_done), 64'(0));
        check("midreset index", 64'(s_index), 64'(0));
        err_done = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            if (s_done || s_busy || s_valid) err_done++;
        end
        check("midreset quiet", 64'(err_done), 64'(0));
        sweep_small(64'h0003_0002_0001_0000, 8'hFF, 1'b0, 32'h0000_0003, "after reset");

        // Start coinciding with reset is dropped.
        step();
        s_start = 1'b1;
        s_reset = 1'b1;
        step();
        s_start = 1'b0;
        s_reset = 1'b0;
        @(negedge clk);
        check("start+reset busy", 64'(s_busy), 64'(0));
        check("start+reset raddr", 64'(s_raddr), 64'(0));
        step();
        @(negedge clk);
        check("start+reset busy later", 64'(s_busy), 64'(0));
        check("start+reset valid", 64'(s_valid), 64'(0));

        for (int i = 0; i < B_DEPTH; i++) b_mem[i] = 16'hFFFF;
        sweep_big(1'b0, "big ffff");
        for (int i = 0; i < B_DEPTH; i++) b_mem[i] = 16'($urandom);
        sweep_big(1'b1, "big random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
